// File: rtl/reflet_rom_prefetch.sv
// Instruction prefetch stage between the program ROM and the CPU decode stage.
// Verifies the 4-byte "ASRM" boot header, then streams program bytes into a
// small credit-limited FIFO presented over a valid/ready handshake.
module reflet_rom_prefetch #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned START_ADDR = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic                  rom_enable,
    input  logic [7:0]            rom_data,
    output logic [7:0]            instr,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    input  logic                  jump,
    input  logic [ADDR_WIDTH-1:0] jump_addr,
    output logic                  header_ok,
    output logic                  header_err
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned DATA_W = 8;
    // "ASRM" packed little-end first: byte i lives at bits [8*i +: 8]
    localparam logic [31:0] HEADER = 32'h4D52_5341;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_RUN,
        S_ERROR
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]   rom_addr_d;
    logic                    rom_enable_d;
    logic                    req_q, req_d;     // request presented on rom_addr this cycle
    logic                    infl_q, infl_d;   // rom_data this cycle belongs to us
    logic [1:0]              hdr_idx_q, hdr_idx_d;
    logic                    header_ok_d, header_err_d;

    logic [DATA_W-1:0]       mem [DEPTH];
    logic [PTR_W-1:0]        rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0]        count_q, count_d, remain;
    logic [DATA_W-1:0]       instr_d;
    logic                    instr_valid_d;
    logic                    run, flush, push, pop;
    logic [DATA_W-1:0]       hdr_byte;

    // Next-state, fetch request, header compare and FIFO bookkeeping
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        rom_addr_d    = rom_addr;
        rom_enable_d  = rom_enable;
        req_d         = 1'b0;
        infl_d        = req_q;
        hdr_idx_d     = hdr_idx_q;
        header_ok_d   = header_ok;
        header_err_d  = header_err;
        hdr_byte      = HEADER[{hdr_idx_q, 3'b000} +: 8];

        // FIFO: a jump in RUN flushes and suppresses both push and pop
        run     = (state_q == S_RUN);
        flush   = run && jump;
        push    = run && !jump && infl_q;
        pop     = run && !jump && instr_valid && instr_ready;
        remain  = count_q - CNT_W'(pop);
        if (flush) begin
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
        end else begin
            rd_d    = rd_q + PTR_W'(pop);
            wr_d    = wr_q + PTR_W'(push);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end

        case (state_q)
            S_IDLE: begin
                // rom_addr already holds 0 from reset, so byte 0 is sampled on this edge
                rom_enable_d = 1'b1;
                infl_d       = 1'b1;
                rom_addr_d   = ADDR_WIDTH'(1);
                req_d        = 1'b1;
                hdr_idx_d    = 2'd0;
                state_d      = S_CHECK;
            end
            S_CHECK: begin
                if (req_q && rom_addr != ADDR_WIDTH'(3)) begin
                    rom_addr_d = rom_addr + ADDR_WIDTH'(1);
                    req_d      = 1'b1;
                end
                if (infl_q) begin
                    if (rom_data != hdr_byte) begin
                        header_err_d = 1'b1;
                        rom_enable_d = 1'b0;
                        rom_addr_d   = rom_addr;
                        req_d        = 1'b0;
                        infl_d       = 1'b0;
                        state_d      = S_ERROR;
                    end else if (hdr_idx_q == 2'd3) begin
                        header_ok_d = 1'b1;
                        rom_addr_d  = ADDR_WIDTH'(START_ADDR);
                        pc_d        = ADDR_WIDTH'(START_ADDR) + ADDR_WIDTH'(1);
                        req_d       = 1'b1;
                        state_d     = S_RUN;
                    end else begin
                        hdr_idx_d = hdr_idx_q + 2'd1;
                    end
                end
            end
            S_RUN: begin
                if (jump) begin
                    infl_d     = 1'b0;
                    rom_addr_d = jump_addr;
                    pc_d       = jump_addr + ADDR_WIDTH'(1);
                    req_d      = 1'b1;
                end else if ((count_d + CNT_W'(infl_d)) < CNT_W'(DEPTH)) begin
                    rom_addr_d = pc_q;
                    pc_d       = pc_q + ADDR_WIDTH'(1);
                    req_d      = 1'b1;
                end
            end
            default: begin
                rom_enable_d = 1'b0;
                infl_d       = 1'b0;
                header_ok_d  = 1'b0;
            end
        endcase

        // Head byte is precomputed so instr/instr_valid leave straight from flops
        if (flush) begin
            instr_d = '0;
        end else if (remain != '0) begin
            instr_d = mem[rd_d];
        end else if (push) begin
            instr_d = rom_data;
        end else begin
            instr_d = '0;
        end
        instr_valid_d = (state_d == S_RUN) && (count_d != '0);
    end

    // State and control registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            rom_addr    <= '0;
            rom_enable  <= 1'b0;
            req_q       <= 1'b0;
            infl_q      <= 1'b0;
            hdr_idx_q   <= 2'd0;
            header_ok   <= 1'b0;
            header_err  <= 1'b0;
            rd_q        <= '0;
            wr_q        <= '0;
            count_q     <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            rom_addr    <= rom_addr_d;
            rom_enable  <= rom_enable_d;
            req_q       <= req_d;
            infl_q      <= infl_d;
            hdr_idx_q   <= hdr_idx_d;
            header_ok   <= header_ok_d;
            header_err  <= header_err_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            count_q     <= count_d;
            instr       <= instr_d;
            instr_valid <= instr_valid_d;
        end
    end

    // FIFO storage; entries are only read after being written
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_q] <= rom_data;
        end
    end

endmodule

// File: tb/tb_reflet_rom_prefetch.sv
// Directed bench for reflet_rom_prefetch with a registered ROM model.
module tb_reflet_rom_prefetch;

    localparam int unsigned AW = 9;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] rom_addr;
    logic          rom_enable;
    logic [7:0]    rom_data;
    logic [7:0]    instr;
    logic          instr_valid;
    logic          instr_ready;
    logic          jump;
    logic [AW-1:0] jump_addr;
    logic          header_ok;
    logic          header_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] rom [512];
    logic [7:0] rom_q;

    always #5 clk = ~clk;

    reflet_rom_prefetch #(.ADDR_WIDTH(AW), .DEPTH(4), .START_ADDR(4)) dut (
        .clk(clk), .reset(reset),
        .rom_addr(rom_addr), .rom_enable(rom_enable), .rom_data(rom_data),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .jump(jump), .jump_addr(jump_addr),
        .header_ok(header_ok), .header_err(header_err)
    );

    // Synchronous ROM: address sampled on the edge, data gated by output enable
    always @(posedge clk) rom_q <= rom[rom_addr];
    assign rom_data = rom_enable ? rom_q : 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_rom(input logic [7:0] byte0);
        for (int i = 0; i < 512; i++) rom[i] = 8'(i * 7 + 3);
        rom[0] = byte0;     rom[1] = 8'h53;     rom[2] = 8'h52;     rom[3] = 8'h4D;
        rom[4] = 8'h14;     rom[5] = 8'h3C;     rom[6] = 8'h10;     rom[7] = 8'h3B;
        rom[9'h0D8] = 8'h3E; rom[9'h0D9] = 8'h0B; rom[9'h0DA] = 8'h10;
        rom[9'h1FF] = 8'hA5;
    endtask

    task automatic check_reset_outputs(input string t);
        check({t, "_rst_addr"},  32'(rom_addr),    32'h0);
        check({t, "_rst_en"},    32'(rom_enable),  32'h0);
        check({t, "_rst_instr"}, 32'(instr),       32'h0);
        check({t, "_rst_valid"}, 32'(instr_valid), 32'h0);
        check({t, "_rst_ok"},    32'(header_ok),   32'h0);
        check({t, "_rst_err"},   32'(header_err),  32'h0);
    endtask

    // Leaves the bench in cycle 0: reset just released at a falling edge
    task automatic do_reset(input string t, input logic rdy);
        jump = 1'b0; jump_addr = '0; instr_ready = rdy;
        reset = 1'b0;
        step(); step();
        check_reset_outputs(t);
        reset = 1'b1;
    endtask

    // Boot timing: header_ok at cycle 5, program bytes from cycle 7; jump in CHECK ignored
    task automatic boot_check(input string t);
        logic [7:0] prog [4];
        prog[0] = 8'h14; prog[1] = 8'h3C; prog[2] = 8'h10; prog[3] = 8'h3B;
        check({t, "_c0_ok"}, 32'(header_ok), 32'h0);
        step(); step();
        jump = 1'b1; jump_addr = 9'h0D8;
        step();
        jump = 1'b0;
        step();
        check({t, "_c4_ok"}, 32'(header_ok), 32'h0);
        step();
        check({t, "_c5_ok"},  32'(header_ok),  32'h1);
        check({t, "_c5_err"}, 32'(header_err), 32'h0);
        step();
        check({t, "_c6_valid"}, 32'(instr_valid), 32'h0);
        step();
        for (int k = 0; k < 4; k++) begin
            check({t, "_valid"}, 32'(instr_valid), 32'h1);
            check({t, "_instr"}, 32'(instr), 32'(prog[k]));
            step();
        end
    endtask

    // Collect n delivered bytes (ready must be 1) and compare against the ROM image
    task automatic expect_stream(input string t, input logic [AW-1:0] start, input int n);
        int got = 0;
        logic [AW-1:0] a;
        for (int c = 0; c < 30 && got < n; c++) begin
            if (instr_valid) begin
                a = start + AW'(got);
                check(t, 32'(instr), 32'(rom[a]));
                got++;
            end
            step();
        end
        if (got < n) check({t, "_timeout"}, 32'(got), 32'(n));
    endtask

    initial begin
        int max_addr;
        int any_valid;
        logic [7:0] exp4 [3];

        reset = 1'b0; jump = 1'b0; jump_addr = '0; instr_ready = 1'b1;

        // Test 1: nominal boot and first program bytes
        load_rom(8'h41);
        do_reset("t1", 1'b1);
        boot_check("t1");

        // Test 2: bad header byte halts the block
        load_rom(8'h42);
        do_reset("t2", 1'b1);
        max_addr = 0; any_valid = 0;
        step(); step();
        check("t2_err", 32'(header_err), 32'h1);
        for (int c = 0; c < 100; c++) begin
            if (int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
            if (instr_valid) any_valid = 1;
            step();
        end
        check("t2_addr_le3", 32'(max_addr > 3), 32'h0);
        check("t2_no_valid", 32'(any_valid), 32'h0);
        check("t2_ok",       32'(header_ok), 32'h0);
        check("t2_err_hold", 32'(header_err), 32'h1);
        check("t2_enable",   32'(rom_enable), 32'h0);

        // Test 3: back-pressure fills exactly DEPTH bytes, then full-rate drain
        load_rom(8'h41);
        do_reset("t3", 1'b0);
        for (int c = 0; c < 15; c++) step();
        check("t3_valid",    32'(instr_valid), 32'h1);
        check("t3_head",     32'(instr), 32'h14);
        check("t3_lastaddr", 32'(rom_addr), 32'h7);
        instr_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            check("t3_rate", 32'(instr_valid), 32'h1);
            check("t3_data", 32'(instr), 32'(rom[4 + k]));
            step();
        end

        // Test 4: jump with 2 buffered and 1 in flight; jump beats a simultaneous pop
        do_reset("t4", 1'b0);
        for (int c = 0; c < 8; c++) step();
        check("t4_pre_valid", 32'(instr_valid), 32'h1);
        check("t4_pre_head",  32'(instr), 32'h14);
        jump = 1'b1; jump_addr = 9'h0D8; instr_ready = 1'b1;
        step();
        jump = 1'b0;
        check("t4_flushed", 32'(instr_valid), 32'h0);
        exp4[0] = 8'h3E; exp4[1] = 8'h0B; exp4[2] = 8'h10;
        begin
            int got = 0;
            for (int c = 0; c < 20 && got < 3; c++) begin
                if (instr_valid) begin
                    check("t4_byte", 32'(instr), 32'(exp4[got]));
                    got++;
                end
                step();
            end
            if (got < 3) check("t4_timeout", 32'(got), 32'h3);
        end

        // Test 5: jump to the last address wraps to 0
        jump = 1'b1; jump_addr = 9'h1FF;
        step();
        jump = 1'b0;
        expect_stream("t5_wrap", 9'h1FF, 4);

        // Test 6: asynchronous reset mid-stream, then a clean re-boot
        #2 reset = 1'b0;
        #1 check_reset_outputs("t6_async");
        step();
        check_reset_outputs("t6_hold");
        reset = 1'b1;
        boot_check("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
